// File: rtl/dec_sel_arb.sv
// Round-robin owner of a shared 3-to-8 select decoder, with a dead cycle between owners.
// Optional DEC_SEL_ARB_LOCK_EN adds a lock input that suppresses hold-limit preemption.
module dec_sel_arb #(
   parameter int HOLD_MAX = 15,
   parameter int CNT_W    = 4
) (
   input  logic       sys_clk,
   input  logic       resetl,
   input  logic [7:0] req,
`ifdef DEC_SEL_ARB_LOCK_EN
   input  logic       lock,
`endif
   output logic       sel_a,
   output logic       sel_b,
   output logic       sel_c,
   output logic       sel_gl,
   output logic [7:0] gnt,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      TURN
   } state_t;

   localparam logic [CNT_W-1:0] LIM =
      CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

   state_t           state, state_nx;
   logic [2:0]       owner, owner_nx, pick, idx;
   logic [CNT_W-1:0] hold_cnt, hold_nx;
   logic             any_req, other_req;
   logic             hold_hit, lock_on, found;

`ifdef DEC_SEL_ARB_LOCK_EN
   assign lock_on = lock;
`else
   assign lock_on = 1'b0;
`endif

   assign any_req   = |req;
   assign other_req = |(req & ~(8'b1 << owner));
   assign hold_hit  = (HOLD_MAX != 0) && (hold_cnt >= LIM)
                      && other_req && !lock_on;

   // Current owner is visited last, giving it the lowest priority.
   always_comb begin
      pick  = owner;
      idx   = owner;
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         idx = owner + 3'(k);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      owner_nx = owner;
      hold_nx  = hold_cnt;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               state_nx = GRANT;
               owner_nx = pick;
               hold_nx  = '0;
            end
         end
         GRANT: begin
            if (hold_cnt != '1)
               hold_nx = hold_cnt + CNT_W'(1);
            if (!req[owner] || hold_hit)
               state_nx = TURN;
         end
         TURN: begin
            if (any_req) begin
               state_nx = GRANT;
               owner_nx = pick;
               hold_nx  = '0;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         state    <= IDLE;
         owner    <= 3'd7;
         hold_cnt <= '0;
         gnt      <= '0;
         sel_gl   <= 1'b1;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         owner    <= owner_nx;
         hold_cnt <= hold_nx;
         gnt      <= (state_nx == GRANT) ? (8'b1 << owner_nx) : 8'b0;
         sel_gl   <= (state_nx != GRANT);
         busy     <= (state_nx != IDLE);
      end
   end

   assign {sel_c, sel_b, sel_a} = owner;

endmodule

// File: tb/tb_dec_sel_arb.sv
// Bench for dec_sel_arb: vector table, reference-model scoreboard, corner sequences.
// Lock checks only run when DEC_SEL_ARB_LOCK_EN is defined.
module tb_dec_sel_arb;

   localparam int HM = 15;

   typedef struct packed {
      logic [7:0] gnt;
      logic       gl;
      logic       busy;
      logic [2:0] cba;
   } exp_t;

   typedef struct packed {
      logic [7:0] req;
      exp_t       e;
   } vec_t;

   logic       sys_clk = 1'b0;
   logic       resetl  = 1'b0;
   logic [7:0] req     = 8'h00;
`ifdef DEC_SEL_ARB_LOCK_EN
   logic       lock    = 1'b0;
`endif
   logic       sel_a, sel_b, sel_c, sel_gl, busy;
   logic [7:0] gnt;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sbq[$];
   logic [7:0] prev_gnt = 8'h00;

   int m_st, m_own, m_len;

   dec_sel_arb #(.HOLD_MAX(HM), .CNT_W(4)) dut (
      .sys_clk(sys_clk),
      .resetl (resetl),
      .req    (req),
`ifdef DEC_SEL_ARB_LOCK_EN
      .lock   (lock),
`endif
      .sel_a  (sel_a),
      .sel_b  (sel_b),
      .sel_c  (sel_c),
      .sel_gl (sel_gl),
      .gnt    (gnt),
      .busy   (busy)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int srch(input logic [7:0] r, input int from);
      for (int d = 1; d <= 8; d++)
         if (r[(from + d) % 8]) return (from + d) % 8;
      return from;
   endfunction

   task automatic model_reset();
      m_st  = 0;
      m_own = 7;
      m_len = 0;
   endtask

   // Behavioural model: m_len counts grant cycles including the current one.
   task automatic model_step(input logic [7:0] r, input logic l,
                             output exp_t e);
      bit others, lk;
      others = 1'b0;
      for (int i = 0; i < 8; i++)
         if (i != m_own && r[i]) others = 1'b1;
`ifdef DEC_SEL_ARB_LOCK_EN
      lk = l;
`else
      lk = 1'b0;
      if (l) lk = 1'b0;
`endif
      if (m_st == 0) begin
         if (r != 0) begin
            m_own = srch(r, m_own);
            m_st  = 1;
            m_len = 1;
         end
      end else if (m_st == 1) begin
         if (!r[m_own] || (HM != 0 && m_len >= HM && others && !lk))
            m_st = 2;
         else
            m_len++;
      end else begin
         if (r != 0) begin
            m_own = srch(r, m_own);
            m_st  = 1;
            m_len = 1;
         end else begin
            m_st = 0;
         end
      end
      e.gnt  = (m_st == 1) ? 8'(1 << m_own) : 8'h00;
      e.gl   = (m_st != 1);
      e.busy = (m_st != 0);
      e.cba  = 3'(m_own);
   endtask

   task automatic cmp_now(input string nm, input exp_t w);
      n_cmp++;
      if ({gnt, sel_gl, busy, sel_c, sel_b, sel_a} !== w) begin
         n_bad++;
         $display("FAIL %s @%0t: got gnt=%h gl=%b busy=%b cba=%b%b%b want gnt=%h gl=%b busy=%b cba=%b",
                  nm, $time, gnt, sel_gl, busy, sel_c, sel_b, sel_a,
                  w.gnt, w.gl, w.busy, w.cba);
      end
   endtask

   task automatic check();
      exp_t w;
      if (sbq.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard: got empty queue want one entry");
         return;
      end
      w = sbq.pop_front();
      cmp_now("outputs", w);
      n_cmp++;
      if ($countones(gnt) > 1) begin
         n_bad++;
         $display("FAIL onehot: got gnt=%h want popcount<=1", gnt);
      end
      if (prev_gnt != 0 && gnt != 0) begin
         n_cmp++;
         if (gnt != prev_gnt) begin
            n_bad++;
            $display("FAIL dead_cycle: got %h after %h want zero cycle between",
                     gnt, prev_gnt);
         end
      end
      prev_gnt = gnt;
   endtask

   task automatic cyc(input logic [7:0] r, input logic l,
                      input bit use_e, input exp_t e_in);
      exp_t em;
      req = r;
`ifdef DEC_SEL_ARB_LOCK_EN
      lock = l;
`endif
      model_step(r, l, em);
      sbq.push_back(use_e ? e_in : em);
      @(posedge sys_clk);
      #1;
      check();
   endtask

   task automatic run(input logic [7:0] r, input logic l, input int n);
      for (int i = 0; i < n; i++) cyc(r, l, 1'b0, '0);
   endtask

   vec_t tbl[15];
   exp_t rst_e;
   int   run_len, last_own, cur_own, runs;

   initial begin
      tbl[0]  = '{8'h01, '{8'h01, 1'b0, 1'b1, 3'b000}};
      tbl[1]  = '{8'h01, '{8'h01, 1'b0, 1'b1, 3'b000}};
      tbl[2]  = '{8'h00, '{8'h00, 1'b1, 1'b1, 3'b000}};
      tbl[3]  = '{8'h00, '{8'h00, 1'b1, 1'b0, 3'b000}};
      tbl[4]  = '{8'h08, '{8'h08, 1'b0, 1'b1, 3'b011}};
      tbl[5]  = '{8'h08, '{8'h08, 1'b0, 1'b1, 3'b011}};
      tbl[6]  = '{8'h02, '{8'h00, 1'b1, 1'b1, 3'b011}};
      tbl[7]  = '{8'h02, '{8'h02, 1'b0, 1'b1, 3'b001}};
      tbl[8]  = '{8'h00, '{8'h00, 1'b1, 1'b1, 3'b001}};
      tbl[9]  = '{8'h00, '{8'h00, 1'b1, 1'b0, 3'b001}};
      tbl[10] = '{8'h04, '{8'h04, 1'b0, 1'b1, 3'b010}};
      tbl[11] = '{8'h00, '{8'h00, 1'b1, 1'b1, 3'b010}};
      tbl[12] = '{8'h10, '{8'h10, 1'b0, 1'b1, 3'b100}};
      tbl[13] = '{8'h00, '{8'h00, 1'b1, 1'b1, 3'b100}};
      tbl[14] = '{8'h00, '{8'h00, 1'b1, 1'b0, 3'b100}};
      rst_e   = '{8'h00, 1'b1, 1'b0, 3'b111};

      model_reset();
      repeat (2) @(posedge sys_clk);
      #1;
      cmp_now("reset_state", rst_e);
      #2 resetl = 1'b1;
      @(posedge sys_clk);
      #1;
      cmp_now("post_reset_idle", rst_e);

      for (int i = 0; i < 15; i++)
         cyc(tbl[i].req, 1'b0, 1'b1, tbl[i].e);

      // Asynchronous reset in the middle of owner 5's grant.
      run(8'h20, 1'b0, 2);
      #2 resetl = 1'b0;
      #1;
      cmp_now("async_reset", rst_e);
      req = 8'hA0;
      #2 resetl = 1'b1;
      model_reset();
      prev_gnt = 8'h00;
      cyc(8'hA0, 1'b0, 1'b1, '{8'h20, 1'b0, 1'b1, 3'b101});
      run(8'h00, 1'b0, 3);

      // Full contention: rotation order and 15-cycle grants.
      run_len  = 0;
      last_own = -1;
      runs     = 0;
      for (int i = 0; i < 150; i++) begin
         cyc(8'hFF, 1'b0, 1'b0, '0);
         if (gnt != 0) begin
            cur_own = 0;
            for (int b = 0; b < 8; b++) if (gnt[b]) cur_own = b;
            if (run_len == 0) begin
               if (last_own >= 0) begin
                  n_cmp++;
                  if (cur_own != (last_own + 1) % 8) begin
                     n_bad++;
                     $display("FAIL rotation: got owner %0d want %0d",
                              cur_own, (last_own + 1) % 8);
                  end
               end
               last_own = cur_own;
            end
            run_len++;
         end else if (run_len != 0) begin
            n_cmp++;
            runs++;
            if (run_len != HM) begin
               n_bad++;
               $display("FAIL grant_len: got %0d want %0d", run_len, HM);
            end
            run_len = 0;
         end
      end
      n_cmp++;
      if (runs < 8) begin
         n_bad++;
         $display("FAIL rotation_count: got %0d want >= 8", runs);
      end
      run(8'h00, 1'b0, 3);

      // Lone requester keeps the grant; saturated counter preempts at once.
      run(8'h20, 1'b0, 40);
      cyc(8'h21, 1'b0, 1'b1, '{8'h00, 1'b1, 1'b1, 3'b101});
      cyc(8'h21, 1'b0, 1'b1, '{8'h01, 1'b0, 1'b1, 3'b000});
      run(8'h21, 1'b0, 3);
      run(8'h00, 1'b0, 3);

`ifdef DEC_SEL_ARB_LOCK_EN
      cyc(8'h04, 1'b0, 1'b1, '{8'h04, 1'b0, 1'b1, 3'b010});
      run(8'h0C, 1'b1, 30);
      cyc(8'h0C, 1'b0, 1'b1, '{8'h00, 1'b1, 1'b1, 3'b010});
      cyc(8'h0C, 1'b0, 1'b1, '{8'h08, 1'b0, 1'b1, 3'b011});
      run(8'h00, 1'b0, 3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
